// File: rtl/rv32i_fetch.sv
// ---------------------------------------------------------------------------
// rv32i_fetch
//
// Instruction fetch stage for a simple in-order RV32I core. The stage keeps
// at most one instruction-memory read in flight. It holds the returned
// instruction for decode, and it handles branch/jump redirects, including
// misaligned redirect targets.
//
// Ports
//   i_clk               clock; all state updates on the rising edge
//   i_rst               synchronous active-high reset
//   o_imem_req          instruction-memory read request (REQ state only)
//   o_imem_addr         request address, always equal to the PC register
//   i_imem_ready        memory accepts the request this cycle
//   i_imem_rvalid       read data valid
//   i_imem_rdata        read data
//   o_fetch_valid       instruction valid to decode (HOLD state only)
//   o_fetch_instruction held instruction
//   o_fetch_pc          PC of the held instruction
//   i_decode_ready      decode consumes the held instruction
//   i_redirect_valid    branch/jump redirect, highest priority after reset
//   i_redirect_pc       redirect target
//   o_misaligned_fault  last redirect target was not word-aligned
//   o_fetch_count       consumed-fetch counter
//
// Build option
//   FETCH_PERF_COUNTER_EN  when defined, o_fetch_count counts decode
//                          handshakes, wrapping at 2^32. When undefined,
//                          o_fetch_count is tied to 0 and no counter flops
//                          are built.
//
// States
//   state | meaning
//   REQ   | request pc from memory, waiting for i_imem_ready
//   WAIT  | request accepted, waiting for i_imem_rvalid
//   HOLD  | instruction presented to decode, waiting for i_decode_ready
//   DRAIN | a redirect orphaned a request; swallow its response
//   FAULT | misaligned redirect target; idle until an aligned redirect
// ---------------------------------------------------------------------------
module rv32i_fetch #(
    parameter int                   INSTRUCTION_WIDTH = 32,
    parameter int                   WORD_SIZE         = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_imem_req,
    output logic [WORD_SIZE-1:0]         o_imem_addr,
    input  logic                         i_imem_ready,
    input  logic                         i_imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
    output logic                         o_fetch_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
    output logic [WORD_SIZE-1:0]         o_fetch_pc,
    input  logic                         i_decode_ready,
    input  logic                         i_redirect_valid,
    input  logic [WORD_SIZE-1:0]         i_redirect_pc,
    output logic                         o_misaligned_fault,
    output logic [31:0]                  o_fetch_count
);

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] pc_d;
    logic                 capture;
    logic                 resp_outstanding;
    logic                 redirect_misaligned;

    assign redirect_misaligned = |i_redirect_pc[1:0];
    assign o_imem_addr         = pc_q;

    // A response is still owed to us after this cycle when a request is
    // accepted now, or when one was accepted earlier and has not returned.
    always_comb begin
        resp_outstanding = 1'b0;
        case (state_q)
            ST_REQ:   resp_outstanding = i_imem_ready;
            ST_WAIT:  resp_outstanding = ~i_imem_rvalid;
            ST_DRAIN: resp_outstanding = ~i_imem_rvalid;
            default:  resp_outstanding = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;

        if (i_redirect_valid) begin
            // A redirect overrides every other handshake this cycle. If a
            // response is still owed to us, that response has to be drained
            // before the stage can issue anything new.
            pc_d = i_redirect_pc;
            if (resp_outstanding) begin
                state_d = ST_DRAIN;
            end else if (redirect_misaligned) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (i_imem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (i_decode_ready) begin
                        pc_d    = pc_q + WORD_SIZE'(4);
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // If a misaligned redirect arrived while draining, the
                    // fault flag remembers it and the stage parks in FAULT.
                    if (i_imem_rvalid) begin
                        state_d = o_misaligned_fault ? ST_FAULT : ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q             <= ST_REQ;
            pc_q                <= RESET_PC;
            o_imem_req          <= 1'b1;
            o_fetch_valid       <= 1'b0;
            o_fetch_instruction <= '0;
            o_fetch_pc          <= '0;
            o_misaligned_fault  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            // The outputs are decoded from the next state. This keeps them
            // registered and still aligned with the state they belong to.
            o_imem_req    <= (state_d == ST_REQ);
            o_fetch_valid <= (state_d == ST_HOLD);
            if (capture) begin
                o_fetch_instruction <= i_imem_rdata;
                o_fetch_pc          <= pc_q;
            end
            if (i_redirect_valid) begin
                o_misaligned_fault <= redirect_misaligned;
            end
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] fetch_count_q;
    logic        count_en;

    // A redirect in HOLD discards the held instruction, so that cycle does
    // not count as a consumed fetch even if decode_ready is also high.
    assign count_en = o_fetch_valid & i_decode_ready & ~i_redirect_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_count_q <= '0;
        end else if (count_en) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count_q;
`else
    assign o_fetch_count = '0;
`endif

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        decode_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        misaligned_fault;
    logic [31:0] fetch_count;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_fetch_valid;
    logic [31:0] w_fetch_instruction;
    logic [31:0] w_fetch_pc;
    logic        w_misaligned_fault;
    logic [31:0] w_fetch_count;

    int          n_checks;
    int          n_fail;
    int          exp_count;

    rv32i_fetch dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .o_imem_req          (imem_req),
        .o_imem_addr         (imem_addr),
        .i_imem_ready        (imem_ready),
        .i_imem_rvalid       (imem_rvalid),
        .i_imem_rdata        (imem_rdata),
        .o_fetch_valid       (fetch_valid),
        .o_fetch_instruction (fetch_instruction),
        .o_fetch_pc          (fetch_pc),
        .i_decode_ready      (decode_ready),
        .i_redirect_valid    (redirect_valid),
        .i_redirect_pc       (redirect_pc),
        .o_misaligned_fault  (misaligned_fault),
        .o_fetch_count       (fetch_count)
    );

    // Same stimulus, PC starting at the top of the address space.
    rv32i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk               (clk),
        .i_rst               (rst),
        .o_imem_req          (w_imem_req),
        .o_imem_addr         (w_imem_addr),
        .i_imem_ready        (imem_ready),
        .i_imem_rvalid       (imem_rvalid),
        .i_imem_rdata        (imem_rdata),
        .o_fetch_valid       (w_fetch_valid),
        .o_fetch_instruction (w_fetch_instruction),
        .o_fetch_pc          (w_fetch_pc),
        .i_decode_ready      (decode_ready),
        .i_redirect_valid    (redirect_valid),
        .i_redirect_pc       (redirect_pc),
        .o_misaligned_fault  (w_misaligned_fault),
        .o_fetch_count       (w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full fetch with ready and rvalid each returning one cycle after
    // the previous step, and decode ready as soon as the instruction is held.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        check("fetch_req_addr", imem_addr, a);
        check("fetch_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check("fetch_wait_noreq", 32'(imem_req), 32'd0);
        check("fetch_wait_novalid", 32'(fetch_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        step();
        imem_rvalid = 1'b0;
        check("fetch_hold_valid", 32'(fetch_valid), 32'd1);
        check("fetch_hold_instr", fetch_instruction, d);
        check("fetch_hold_pc", fetch_pc, a);
        check("fetch_hold_noreq", 32'(imem_req), 32'd0);
        decode_ready = 1'b1;
        step();
        exp_count++;
        check("fetch_done_valid", 32'(fetch_valid), 32'd0);
        check("fetch_next_req", 32'(imem_req), 32'd1);
        check("fetch_next_addr", imem_addr, a + 32'd4);
    endtask

    initial begin
        logic [31:0] count_exp;
        n_checks       = 0;
        n_fail         = 0;
        exp_count      = 0;
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        decode_ready   = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset; a redirect during reset must be ignored.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr", fetch_instruction, 32'd0);
        check("rst_pc", fetch_pc, 32'd0);
        check("rst_fault", 32'(misaligned_fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        rst = 1'b0;
        step();
        check("post_rst_req", 32'(imem_req), 32'd1);

        // Back-to-back sequential fetches.
        do_fetch(32'h0000_0000, 32'h0010_0093);
        check("wrap_next_addr", w_imem_addr, 32'h0000_0000);
        check("wrap_held_pc", w_fetch_pc, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0004, 32'h0020_0113);
        do_fetch(32'h0000_0008, 32'h0030_0193);

        // Decode stalls for 5 cycles in HOLD.
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        step();
        imem_rvalid  = 1'b0;
        decode_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(fetch_valid), 32'd1);
            check("stall_instr", fetch_instruction, 32'h0000_0013);
            check("stall_pc", fetch_pc, 32'h0000_000C);
            check("stall_noreq", 32'(imem_req), 32'd0);
        end
        decode_ready = 1'b1;
        step();
        exp_count++;
        check("stall_next_req", 32'(imem_req), 32'd1);
        check("stall_next_addr", imem_addr, 32'h0000_0010);

        // Redirect while waiting; the late response is drained.
        imem_ready = 1'b1;
        step();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("drain_noreq", 32'(imem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("drain_wait_noreq", 32'(imem_req), 32'd0);
            check("drain_wait_novalid", 32'(fetch_valid), 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("drain_done_novalid", 32'(fetch_valid), 32'd0);
        check("drain_discard_instr", fetch_instruction, 32'h0000_0013);
        check("drain_done_req", 32'(imem_req), 32'd1);
        check("drain_done_addr", imem_addr, 32'h0000_0100);
        do_fetch(32'h0000_0100, 32'h0040_0213);

        // Misaligned redirect with nothing outstanding goes straight to FAULT.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        check("fault_set", 32'(misaligned_fault), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("fault_noreq", 32'(imem_req), 32'd0);
            step();
        end
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("fault_clear", 32'(misaligned_fault), 32'd0);
        do_fetch(32'h0000_0200, 32'h0050_0293);

        // Misaligned redirect in the same cycle as an accepted request:
        // DRAIN first, then FAULT.
        imem_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0306;
        step();
        imem_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("mis_drain_fault", 32'(misaligned_fault), 32'd1);
        check("mis_drain_noreq", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        step();
        check("mis_fault_noreq", 32'(imem_req), 32'd0);
        check("mis_fault_novalid", 32'(fetch_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        check("mis_fault_clear", 32'(misaligned_fault), 32'd0);
        do_fetch(32'h0000_0300, 32'h0060_0313);

        // Redirect in WAIT coinciding with the response: the data is dropped
        // and the stage requests the target on the next cycle.
        imem_ready = 1'b1;
        step();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h0BAD_0BAD;
        step();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        check("redir_rv_req", 32'(imem_req), 32'd1);
        check("redir_rv_addr", imem_addr, 32'h0000_0400);
        check("redir_rv_novalid", 32'(fetch_valid), 32'd0);
        do_fetch(32'h0000_0400, 32'h0070_0393);
        do_fetch(32'h0000_0404, 32'h0080_0413);
        do_fetch(32'h0000_0408, 32'h0090_0493);

`ifdef FETCH_PERF_COUNTER_EN
        count_exp = 32'(exp_count);
`else
        count_exp = 32'd0;
`endif
        check("fetch_count", fetch_count, count_exp);
        check("fetch_count_ten", 32'(exp_count), 32'd10);

        // Reset with a request outstanding.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_valid", 32'(fetch_valid), 32'd0);
        check("midrst_instr", fetch_instruction, 32'd0);
        step();
        check("midrst_req", 32'(imem_req), 32'd1);

        // A response arriving in REQ must be ignored.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        check("stray_rv_req", 32'(imem_req), 32'd1);
        check("stray_rv_novalid", 32'(fetch_valid), 32'd0);
        check("stray_rv_instr", fetch_instruction, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
